// File: rtl/ps2_pkg.sv
// PS/2 receive path shared definitions: scancodes, rx FSM states,
// and the game-key scancode map returning {hit, index}.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_E = 8'h24;
    localparam logic [7:0] SC_F = 8'h2B;
    localparam logic [7:0] SC_G = 8'h34;
    localparam logic [7:0] SC_R = 8'h2D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_T = 8'h2C;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } rx_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_map_t;

    function automatic key_map_t map_scancode(
        input logic [7:0] code
    );
        key_map_t m;
        m.hit = 1'b1;
        m.idx = 3'd0;
        case (code)
            SC_A:    m.idx = 3'd0;
            SC_D:    m.idx = 3'd1;
            SC_E:    m.idx = 3'd2;
            SC_F:    m.idx = 3'd3;
            SC_G:    m.idx = 3'd4;
            SC_R:    m.idx = 3'd5;
            SC_S:    m.idx = 3'd6;
            SC_T:    m.idx = 3'd7;
            default: m.hit = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge detect,
// IDLE/SHIFT/CHECK FSM, inactivity timeout and start/parity/stop checks.
// Ports: clk, reset (async high), ps2_clk, ps2_data (raw pins);
//        byte_valid (1-cycle, good frame), rx_byte, frame_err (1-cycle).
import ps2_pkg::*;

module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] csync;
    logic [SYNC_STAGES-1:0] dsync;
    logic                   clk_q;
    logic                   fall;
    logic                   din;

    rx_state_t   state;
    rx_state_t   next;
    logic [10:0] sr;
    logic [3:0]  bitcnt;
    logic [TW-1:0] tcnt;
    logic        tmo;
    logic        ok;

    // Synchronisers idle high so reset never fakes a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csync <= '1;
            dsync <= '1;
            clk_q <= 1'b1;
        end else begin
            csync <= {csync[SYNC_STAGES-2:0], ps2_clk};
            dsync <= {dsync[SYNC_STAGES-2:0], ps2_data};
            clk_q <= csync[SYNC_STAGES-1];
        end
    end

    assign fall = clk_q & ~csync[SYNC_STAGES-1];
    assign din  = dsync[SYNC_STAGES-1];

    assign tmo = (state == SHIFT) && !fall && (tcnt == TLIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (fall) next = SHIFT;
            end
            SHIFT: begin
                if (fall && bitcnt == 4'd10) next = CHECK;
                else if (tmo)                next = IDLE;
            end
            CHECK: begin
                next = IDLE;
            end
            default: begin
                next = IDLE;
            end
        endcase
    end

    // LSB-first: after 11 edges sr[0]=start, sr[8:1]=data,
    // sr[9]=parity, sr[10]=stop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr     <= '0;
            bitcnt <= '0;
            tcnt   <= '0;
        end else begin
            if (fall && state != CHECK) begin
                sr <= {din, sr[10:1]};
            end
            if (fall && state == IDLE) begin
                bitcnt <= 4'd1;
            end else if (fall && state == SHIFT) begin
                bitcnt <= bitcnt + 4'd1;
            end
            if (fall || state != SHIFT) begin
                tcnt <= '0;
            end else if (!tmo) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    always_comb begin
        ok         = ~sr[0] & (^sr[9:1]) & sr[10];
        rx_byte    = sr[8:1];
        byte_valid = (state == CHECK) && ok;
        frame_err  = ((state == CHECK) && !ok) || tmo;
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard game-key receiver: F0/E0 prefix tracking, scancode
// mapping and registered key events. Optional build macro
// PS2_KEY_TYPEMATIC_FILTER_EN drops make events for keys already held.
// Ports: clk, reset (async high), ps2_clk, ps2_data, en;
//        key_valid, key_value, key_release, key_ext, frame_err.
import ps2_pkg::*;

module ps2_key_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int KEY_W          = 4,
    parameter int NO_KEY         = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             en,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_value,
    output logic             key_release,
    output logic             key_ext,
    output logic             frame_err
);

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       break_f;
    logic       ext_f;
    logic       is_brk;
    logic       is_ext;
    logic       final_b;
    logic       suppress;
    logic       fire;
    key_map_t   m;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign m       = map_scancode(rx_byte);
    assign is_brk  = (rx_byte == PS2_BREAK);
    assign is_ext  = (rx_byte == PS2_EXT);
    assign final_b = byte_valid && !is_brk && !is_ext;

`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
    logic [7:0] held;

    // A repeated make for a held key is keyboard auto-repeat.
    assign suppress = !break_f && held[m.idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held <= '0;
        end else if (final_b && m.hit && en) begin
            held[m.idx] <= !break_f;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    assign fire = final_b && m.hit && en && !suppress;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            break_f     <= 1'b0;
            ext_f       <= 1'b0;
            key_valid   <= 1'b0;
            key_value   <= KEY_W'(NO_KEY);
            key_release <= 1'b0;
            key_ext     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (byte_valid && is_brk) begin
                break_f <= 1'b1;
            end else if (byte_valid && is_ext) begin
                ext_f <= 1'b1;
            end else if (final_b) begin
                break_f <= 1'b0;
                ext_f   <= 1'b0;
            end
            if (fire) begin
                key_valid   <= 1'b1;
                key_value   <= KEY_W'(m.idx);
                key_release <= break_f;
                key_ext     <= ext_f;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: table of frames with
// expected events, plus latency, timeout, reset and repeat sequences.
module tb_ps2_key_receiver;

    localparam int S = 2;
    localparam int T = 300;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       en = 1'b1;
    logic       key_valid;
    logic [3:0] key_value;
    logic       key_release;
    logic       key_ext;
    logic       frame_err;

    ps2_key_receiver #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (T),
        .KEY_W          (4),
        .NO_KEY         (9)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .en          (en),
        .key_valid   (key_valid),
        .key_value   (key_value),
        .key_release (key_release),
        .key_ext     (key_ext),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int kv_n = 0;
    int fe_n = 0;
    int kv_cyc = 0;
    int fe_cyc = 0;
    int t_last = 0;
    int nchk = 0;
    int nerr = 0;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_n   = kv_n + 1;
            kv_cyc = cyc;
        end
        if (frame_err) begin
            fe_n   = fe_n + 1;
            fe_cyc = cyc;
        end
    end

    typedef struct {
        logic [7:0] code;
        logic       en;
        logic       flip;
        int         kv;
        int         val;
        int         rel;
        int         ext;
        int         fe;
    } vec_t;

    vec_t v[16];

    task automatic check(input string name, input int got, input int exp);
        nchk = nchk + 1;
        if (got !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] frame(
        input logic [7:0] code,
        input logic       flip
    );
        return {1'b1, ~(^code) ^ flip, code, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = b[i];
            wait_neg(H);
            ps2_clk = 1'b0;
            t_last  = cyc;
            wait_neg(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] code);
        send_bits(frame(code, 1'b0), 11);
        wait_neg(10);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int kv0;
        int fe0;
        int n;

        v[0]  = '{8'hF0, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        v[1]  = '{8'h23, 1'b1, 1'b0, 1, 1, 1, 0, 0};
        v[2]  = '{8'hE0, 1'b1, 1'b0, 0, 1, 1, 0, 0};
        v[3]  = '{8'hF0, 1'b1, 1'b0, 0, 1, 1, 0, 0};
        v[4]  = '{8'h2C, 1'b1, 1'b0, 1, 7, 1, 1, 0};
        v[5]  = '{8'h24, 1'b1, 1'b0, 1, 2, 0, 0, 0};
        v[6]  = '{8'h1C, 1'b1, 1'b1, 0, 2, 0, 0, 1};
        v[7]  = '{8'h1D, 1'b1, 1'b0, 0, 2, 0, 0, 0};
        v[8]  = '{8'h1C, 1'b0, 1'b0, 0, 2, 0, 0, 0};
        v[9]  = '{8'hF0, 1'b1, 1'b0, 0, 2, 0, 0, 0};
        v[10] = '{8'h1C, 1'b1, 1'b1, 0, 2, 0, 0, 1};
        v[11] = '{8'h34, 1'b1, 1'b0, 1, 4, 1, 0, 0};
        v[12] = '{8'h2D, 1'b1, 1'b0, 1, 5, 0, 0, 0};
        v[13] = '{8'h1B, 1'b1, 1'b0, 1, 6, 0, 0, 0};
        v[14] = '{8'hE0, 1'b1, 1'b0, 0, 6, 0, 0, 0};
        v[15] = '{8'h1D, 1'b1, 1'b0, 0, 6, 0, 0, 0};

        wait_neg(5);
        check("rst_valid", int'(key_valid), 0);
        check("rst_value", int'(key_value), 9);
        check("rst_rel", int'(key_release), 0);
        check("rst_ext", int'(key_ext), 0);
        check("rst_ferr", int'(frame_err), 0);
        reset = 1'b0;
        wait_neg(3);

        kv0 = kv_n;
        send(8'h1C);
        check("first_kv", kv_n - kv0, 1);
        check("first_lat", kv_cyc - t_last, S + 2);
        check("first_val", int'(key_value), 0);
        check("first_rel", int'(key_release), 0);
        check("first_ext", int'(key_ext), 0);

        for (int i = 0; i < 16; i++) begin
            kv0 = kv_n;
            fe0 = fe_n;
            en  = v[i].en;
            send_bits(frame(v[i].code, v[i].flip), 11);
            wait_neg(10);
            en = 1'b1;
            check($sformatf("v%0d_kv", i), kv_n - kv0, v[i].kv);
            check($sformatf("v%0d_val", i), int'(key_value), v[i].val);
            check($sformatf("v%0d_rel", i), int'(key_release), v[i].rel);
            check($sformatf("v%0d_ext", i), int'(key_ext), v[i].ext);
            check($sformatf("v%0d_fe", i), fe_n - fe0, v[i].fe);
        end

        kv0 = kv_n;
        fe0 = fe_n;
        send_bits(frame(8'h2B, 1'b0), 4);
        n = 0;
        while (fe_n == fe0 && n < T + 50) begin
            @(negedge clk);
            n++;
        end
        check("tmo_fe", fe_n - fe0, 1);
        check("tmo_lat", fe_cyc - t_last, S + T);
        check("tmo_kv", kv_n - kv0, 0);
        send(8'h2B);
        check("after_tmo_kv", kv_n - kv0, 1);
        check("after_tmo_val", int'(key_value), 3);
        check("after_tmo_rel", int'(key_release), 0);
        check("after_tmo_ext", int'(key_ext), 0);

        send_bits(frame(8'h1B, 1'b0), 5);
        @(negedge clk);
        reset = 1'b1;
        wait_neg(3);
        check("mid_rst_valid", int'(key_valid), 0);
        check("mid_rst_value", int'(key_value), 9);
        check("mid_rst_rel", int'(key_release), 0);
        check("mid_rst_ext", int'(key_ext), 0);
        check("mid_rst_ferr", int'(frame_err), 0);
        reset = 1'b0;
        fe0 = fe_n;
        wait_neg(T + 20);
        check("mid_rst_no_tmo", fe_n - fe0, 0);
        kv0 = kv_n;
        send(8'h2D);
        check("post_rst_kv", kv_n - kv0, 1);
        check("post_rst_val", int'(key_value), 5);
        check("post_rst_fe", fe_n - fe0, 0);

        @(negedge clk);
        reset = 1'b1;
        wait_neg(2);
        reset = 1'b0;
        wait_neg(2);
        kv0 = kv_n;
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        send(8'h1C);
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
        check("repeat_kv", kv_n - kv0, 3);
`else
        check("repeat_kv", kv_n - kv0, 4);
`endif
        check("repeat_val", int'(key_value), 0);
        check("repeat_rel", int'(key_release), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
